dmem_controller: RTL and testbench

Memory-side responder for the load buffer and ROB store-commit path. Accepts one load or one store request at a time, drives `mem_busy` back to the requesters, runs the tagged request/response handshake with data memory, and returns sign- or zero-extended load results with their ROB tag on a single-cycle writeback pulse. Sits between the load buffer / ROB commit and the processor-to-memory bus.

---
 rtl/dmem_controller.sv | 216 +++++++++++++++++++++
 tb/tb_dmem_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_controller.sv
// dmem_controller: single-outstanding data-memory responder for the load
// buffer and the ROB store-commit path. Runs the tagged request/response
// handshake with memory and returns extended load results with their ROB tag.
// Configuration macro: DMEM_STORE_PRIORITY_EN -- when defined, a simultaneous
// store and load request in IDLE takes the store; otherwise the load wins.
module dmem_controller #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_req,
    input  logic [XLEN-1:0]        load_address,
    input  logic [ROB_TAG_LEN-1:0] load_rob_tag,
    input  logic [2:0]             load_mem_size,
    input  logic                   store_req,
    input  logic [XLEN-1:0]        store_address,
    input  logic [XLEN-1:0]        store_data,
    input  logic [2:0]             store_mem_size,
    output logic                   mem_busy,
    output logic [1:0]             proc2mem_command,
    output logic [XLEN-1:0]        proc2mem_addr,
    output logic [1:0]             proc2mem_size,
    output logic [63:0]            proc2mem_data,
    input  logic [3:0]             mem2proc_response,
    input  logic [63:0]            mem2proc_data,
    input  logic [3:0]             mem2proc_tag,
    output logic                   load_result_valid,
    output logic [ROB_TAG_LEN-1:0] load_result_tag,
    output logic [XLEN-1:0]        load_result_value,
    output logic                   store_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_REQ  = 2'd1,
        LD_WAIT = 2'd2,
        ST_REQ  = 2'd3
    } state_t;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [2:0]             size_q, size_d;
    logic [ROB_TAG_LEN-1:0] rob_tag_q, rob_tag_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [3:0]             pending_tag_q, pending_tag_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cmd_q, cmd_d;
    logic                   result_valid_q, result_valid_d;
    logic [ROB_TAG_LEN-1:0] result_tag_q, result_tag_d;
    logic [XLEN-1:0]        result_value_q, result_value_d;
    logic                   store_done_q, store_done_d;
    logic                   take_load_s, take_store_s;

    // Store payload: right-justified data, zero-padded, masked to the access size.
    function automatic logic [63:0] store_payload(input logic [XLEN-1:0] data,
                                                  input logic [2:0] size);
        logic [63:0] mask;
        case (size[1:0])
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return 64'(data) & mask;
    endfunction

    // Load extraction: pick the lane (offset forced down to alignment) and extend.
    function automatic logic [XLEN-1:0] load_extract(input logic [63:0] block,
                                                     input logic [2:0] off,
                                                     input logic [2:0] size);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] ext;
        b   = 8'(block >> {off, 3'b000});
        h   = 16'(block >> {off[2:1], 1'b0, 3'b000});
        w   = 32'(block >> {off[2], 2'b00, 3'b000});
        case (size[1:0])
            2'd0: begin
                if (size[2]) ext = {{(XLEN-8){1'b0}}, b};
                else         ext = {{(XLEN-8){b[7]}}, b};
            end
            2'd1: begin
                if (size[2]) ext = {{(XLEN-16){1'b0}}, h};
                else         ext = {{(XLEN-16){h[15]}}, h};
            end
            default: ext = XLEN'(w);
        endcase
        return ext;
    endfunction

    // Arbitration between simultaneous load and store requests in IDLE.
    always_comb begin
`ifdef DMEM_STORE_PRIORITY_EN
        take_store_s = store_req;
        take_load_s  = load_req && !store_req;
`else
        take_load_s  = load_req;
        take_store_s = store_req && !load_req;
`endif
    end

    // Next-state, latched request fields and registered output values.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        rob_tag_d      = rob_tag_q;
        wdata_d        = wdata_q;
        pending_tag_d  = pending_tag_q;
        result_valid_d = 1'b0;
        result_tag_d   = result_tag_q;
        result_value_d = result_value_q;
        store_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_load_s) begin
                    state_d   = LD_REQ;
                    addr_d    = load_address;
                    size_d    = load_mem_size;
                    rob_tag_d = load_rob_tag;
                    wdata_d   = 64'd0;
                end else if (take_store_s) begin
                    state_d = ST_REQ;
                    addr_d  = store_address;
                    size_d  = store_mem_size;
                    wdata_d = store_payload(store_data, store_mem_size);
                end else begin
                    state_d = IDLE;
                end
            end
            LD_REQ: begin
                if (mem2proc_response != 4'd0) begin
                    pending_tag_d = mem2proc_response;
                    state_d       = LD_WAIT;
                end else begin
                    state_d = LD_REQ;
                end
            end
            LD_WAIT: begin
                if ((pending_tag_q != 4'd0) && (mem2proc_tag == pending_tag_q)) begin
                    result_valid_d = 1'b1;
                    result_tag_d   = rob_tag_q;
                    result_value_d = load_extract(mem2proc_data, addr_q[2:0], size_q);
                    pending_tag_d  = 4'd0;
                    state_d        = IDLE;
                end else begin
                    state_d = LD_WAIT;
                end
            end
            ST_REQ: begin
                if (mem2proc_response != 4'd0) begin
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        // Bus outputs are registered from the state being entered.
        busy_d = (state_d != IDLE);
        case (state_d)
            LD_REQ:  cmd_d = BUS_LOAD;
            ST_REQ:  cmd_d = BUS_STORE;
            default: cmd_d = BUS_NONE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            size_q         <= 3'd0;
            rob_tag_q      <= '0;
            wdata_q        <= 64'd0;
            pending_tag_q  <= 4'd0;
            busy_q         <= 1'b0;
            cmd_q          <= BUS_NONE;
            result_valid_q <= 1'b0;
            result_tag_q   <= '0;
            result_value_q <= '0;
            store_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            rob_tag_q      <= rob_tag_d;
            wdata_q        <= wdata_d;
            pending_tag_q  <= pending_tag_d;
            busy_q         <= busy_d;
            cmd_q          <= cmd_d;
            result_valid_q <= result_valid_d;
            result_tag_q   <= result_tag_d;
            result_value_q <= result_value_d;
            store_done_q   <= store_done_d;
        end
    end

    assign mem_busy          = busy_q;
    assign proc2mem_command  = cmd_q;
    assign proc2mem_addr     = addr_q;
    assign proc2mem_size     = size_q[1:0];
    assign proc2mem_data     = wdata_q;
    assign load_result_valid = result_valid_q;
    assign load_result_tag   = result_tag_q;
    assign load_result_value = result_value_q;
    assign store_done        = store_done_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: directed scenarios followed by
// randomized loads/stores checked against an arithmetic reference model.
module tb_dmem_controller;

    localparam int XLEN = 32;
    localparam int RTL  = 6;

    logic            clock;
    logic            reset;
    logic            load_req;
    logic [31:0]     load_address;
    logic [RTL-1:0]  load_rob_tag;
    logic [2:0]      load_mem_size;
    logic            store_req;
    logic [31:0]     store_address;
    logic [31:0]     store_data;
    logic [2:0]      store_mem_size;
    logic            mem_busy;
    logic [1:0]      proc2mem_command;
    logic [31:0]     proc2mem_addr;
    logic [1:0]      proc2mem_size;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    logic            load_result_valid;
    logic [RTL-1:0]  load_result_tag;
    logic [31:0]     load_result_value;
    logic            store_done;

    int n_cmp = 0;
    int n_err = 0;

    dmem_controller #(.XLEN(XLEN), .ROB_TAG_LEN(RTL)) dut (
        .clock(clock), .reset(reset),
        .load_req(load_req), .load_address(load_address),
        .load_rob_tag(load_rob_tag), .load_mem_size(load_mem_size),
        .store_req(store_req), .store_address(store_address),
        .store_data(store_data), .store_mem_size(store_mem_size),
        .mem_busy(mem_busy), .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .proc2mem_size(proc2mem_size),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .load_result_valid(load_result_valid), .load_result_tag(load_result_tag),
        .load_result_value(load_result_value), .store_done(store_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: bytes in the access, lane forced down to alignment, then extend.
    function automatic logic [31:0] ref_load(input logic [63:0] blk, input logic [31:0] addr,
                                             input logic [2:0] sz);
        longint unsigned v;
        longint unsigned m;
        int n;
        int off;
        n   = (sz[1:0] == 2'd0) ? 1 : ((sz[1:0] == 2'd1) ? 2 : 4);
        off = (int'(addr % 32'd8) / n) * n;
        v   = blk >> (8 * off);
        m   = 64'd1 << (8 * n);
        v   = v % m;
        if (!sz[2] && n < 4 && v >= m / 2) v = v + (64'h1_0000_0000 - m);
        return 32'(v);
    endfunction

    function automatic logic [63:0] ref_store(input logic [31:0] data, input logic [2:0] sz);
        longint unsigned m;
        if (sz[1:0] >= 2'd2) return 64'(data);
        m = 64'd1 << (8 * (1 << sz[1:0]));
        return 64'(data) % m;
    endfunction

    task automatic do_load(input logic [31:0] addr, input logic [2:0] sz, input logic [RTL-1:0] rtag,
                           input logic [63:0] blk, input int n_rej, input logic [3:0] mtag,
                           input int wait_cyc, input logic [3:0] noise, input logic [31:0] exp_val);
        load_req = 1'b1; load_address = addr; load_mem_size = sz; load_rob_tag = rtag;
        tick;
        load_req = 1'b0;
        for (int i = 0; i < n_rej; i++) begin
            chk("ld_cmd_retry", 64'(proc2mem_command), 64'd1);
            chk("ld_busy_retry", 64'(mem_busy), 64'd1);
            mem2proc_response = 4'd0; mem2proc_tag = mtag; mem2proc_data = ~blk;
            tick;
            chk("ld_no_early_result", 64'(load_result_valid), 64'd0);
        end
        chk("ld_cmd", 64'(proc2mem_command), 64'd1);
        chk("ld_addr", 64'(proc2mem_addr), 64'(addr));
        chk("ld_size", 64'(proc2mem_size), 64'(sz[1:0]));
        chk("ld_busy", 64'(mem_busy), 64'd1);
        mem2proc_response = mtag; mem2proc_tag = 4'd0;
        tick;
        mem2proc_response = 4'd0;
        for (int i = 0; i < wait_cyc; i++) begin
            chk("ld_wait_cmd", 64'(proc2mem_command), 64'd0);
            chk("ld_wait_valid", 64'(load_result_valid), 64'd0);
            mem2proc_tag = noise; mem2proc_data = ~blk;
            tick;
        end
        chk("ld_wait_busy", 64'(mem_busy), 64'd1);
        chk("ld_wait_valid", 64'(load_result_valid), 64'd0);
        mem2proc_tag = mtag; mem2proc_data = blk;
        tick;
        mem2proc_tag = 4'd0;
        chk("ld_valid", 64'(load_result_valid), 64'd1);
        chk("ld_tag", 64'(load_result_tag), 64'(rtag));
        chk("ld_value", 64'(load_result_value), 64'(exp_val));
        chk("ld_busy_low", 64'(mem_busy), 64'd0);
        tick;
        chk("ld_valid_pulse", 64'(load_result_valid), 64'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sz,
                            input int n_rej, input logic [3:0] rsp, input logic [63:0] exp_data);
        store_req = 1'b1; store_address = addr; store_data = data; store_mem_size = sz;
        tick;
        store_req = 1'b0;
        for (int i = 0; i <= n_rej; i++) begin
            chk("st_cmd", 64'(proc2mem_command), 64'd2);
            chk("st_busy", 64'(mem_busy), 64'd1);
            chk("st_addr", 64'(proc2mem_addr), 64'(addr));
            chk("st_size", 64'(proc2mem_size), 64'(sz[1:0]));
            chk("st_data", proc2mem_data, exp_data);
            chk("st_done_early", 64'(store_done), 64'd0);
            mem2proc_response = (i == n_rej) ? rsp : 4'd0;
            tick;
        end
        mem2proc_response = 4'd0;
        chk("st_done", 64'(store_done), 64'd1);
        chk("st_busy_low", 64'(mem_busy), 64'd0);
        chk("st_cmd_none", 64'(proc2mem_command), 64'd0);
        tick;
        chk("st_done_pulse", 64'(store_done), 64'd0);
    endtask

    initial begin
        logic [2:0]  ld_sizes [5];
        logic [31:0] a;
        logic [31:0] d;
        logic [63:0] blk;
        logic [2:0]  sz;
        logic [3:0]  mtag;
        logic [3:0]  noise;
        logic [RTL-1:0] rt;
        ld_sizes[0] = 3'd0; ld_sizes[1] = 3'd1; ld_sizes[2] = 3'd2;
        ld_sizes[3] = 3'd4; ld_sizes[4] = 3'd5;

        reset = 1'b1; load_req = 1'b0; store_req = 1'b0;
        load_address = 32'd0; load_rob_tag = '0; load_mem_size = 3'd0;
        store_address = 32'd0; store_data = 32'd0; store_mem_size = 3'd0;
        mem2proc_response = 4'd0; mem2proc_data = 64'd0; mem2proc_tag = 4'd0;
        tick; tick;
        chk("rst_busy", 64'(mem_busy), 64'd0);
        chk("rst_cmd", 64'(proc2mem_command), 64'd0);
        chk("rst_addr", 64'(proc2mem_addr), 64'd0);
        chk("rst_data", proc2mem_data, 64'd0);
        chk("rst_valid", 64'(load_result_valid), 64'd0);
        chk("rst_rtag", 64'(load_result_tag), 64'd0);
        chk("rst_rval", 64'(load_result_value), 64'd0);
        chk("rst_sdone", 64'(store_done), 64'd0);
        reset = 1'b0;
        tick;

        // LW at 0x104: upper word of the block.
        do_load(32'h104, 3'd2, 6'd5, 64'h1122_3344_5566_7788, 0, 4'd3, 4, 4'd0, 32'h1122_3344);
        // LB / LBU at 0x1001 with byte1 = 0x80.
        do_load(32'h1001, 3'd0, 6'd6, 64'h0123_4567_89AB_80CD, 0, 4'd1, 1, 4'd0, 32'hFFFF_FF80);
        do_load(32'h1001, 3'd4, 6'd7, 64'h0123_4567_89AB_80CD, 0, 4'd1, 1, 4'd0, 32'h0000_0080);
        // Misaligned half at offset 7 uses lane 6.
        do_load(32'h2007, 3'd1, 6'd8, 64'h9876_0000_0000_0000, 1, 4'd5, 0, 4'd0, 32'hFFFF_9876);
        // Retry twice, then accepted with tag 2; tag 7 in LD_WAIT ignored.
        do_load(32'h40, 3'd2, 6'd1, 64'hAAAA_BBBB_CCCC_DDDD, 2, 4'd2, 3, 4'd7, 32'hCCCC_DDDD);
        // SH at 0x2002.
        do_store(32'h2002, 32'hABCD_1234, 3'd1, 0, 4'd1, 64'h0000_0000_0000_1234);
        do_store(32'h3003, 32'hABCD_12F4, 3'd4, 2, 4'd9, 64'h0000_0000_0000_00F4);

        // Simultaneous load and store in IDLE.
        load_req = 1'b1; load_address = 32'h3000; load_mem_size = 3'd2; load_rob_tag = 6'd9;
        store_req = 1'b1; store_address = 32'h4004; store_data = 32'hCAFE_F00D; store_mem_size = 3'd2;
        tick;
        load_req = 1'b0; store_req = 1'b0;
`ifdef DMEM_STORE_PRIORITY_EN
        chk("both_cmd", 64'(proc2mem_command), 64'd2);
        chk("both_addr", 64'(proc2mem_addr), 64'h4004);
        chk("both_data", proc2mem_data, 64'h0000_0000_CAFE_F00D);
        mem2proc_response = 4'd6;
        tick;
        mem2proc_response = 4'd0;
        chk("both_done", 64'(store_done), 64'd1);
`else
        chk("both_cmd", 64'(proc2mem_command), 64'd1);
        chk("both_addr", 64'(proc2mem_addr), 64'h3000);
        mem2proc_response = 4'd6;
        tick;
        mem2proc_response = 4'd0;
        mem2proc_tag = 4'd6; mem2proc_data = 64'h1234_5678_9ABC_DEF0;
        tick;
        mem2proc_tag = 4'd0;
        chk("both_valid", 64'(load_result_valid), 64'd1);
        chk("both_value", 64'(load_result_value), 64'h9ABC_DEF0);
        chk("both_tag", 64'(load_result_tag), 64'd9);
`endif
        chk("both_idle", 64'(mem_busy), 64'd0);
        tick;

        // Reset during LD_WAIT with tag 4 outstanding.
        load_req = 1'b1; load_address = 32'h500; load_mem_size = 3'd2; load_rob_tag = 6'd3;
        tick;
        load_req = 1'b0;
        mem2proc_response = 4'd4;
        tick;
        mem2proc_response = 4'd0;
        chk("rstmid_busy", 64'(mem_busy), 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstmid_busy_low", 64'(mem_busy), 64'd0);
        chk("rstmid_cmd", 64'(proc2mem_command), 64'd0);
        mem2proc_tag = 4'd4; mem2proc_data = 64'h5555_6666_7777_8888;
        tick;
        mem2proc_tag = 4'd0;
        chk("rstmid_no_valid", 64'(load_result_valid), 64'd0);
        chk("rstmid_idle", 64'(mem_busy), 64'd0);
        tick;
        chk("rstmid_no_valid2", 64'(load_result_valid), 64'd0);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            a = $urandom;
            d = $urandom;
            blk = {$urandom, $urandom};
            mtag = 4'($urandom_range(1, 15));
            noise = 4'(((int'(mtag) + $urandom_range(0, 13)) % 15) + 1);
            rt = RTL'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                sz = ld_sizes[$urandom_range(0, 4)];
                do_load(a, sz, rt, blk, $urandom_range(0, 2), mtag, $urandom_range(0, 3), noise,
                        ref_load(blk, a, sz));
            end else begin
                sz = 3'($urandom_range(0, 7));
                do_store(a, d, sz, $urandom_range(0, 2), mtag, ref_store(d, sz));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
